// File: rtl/and_pkg.sv
// Shared widths and FSM encoding for the and_gate operand loader.
package and_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_BYTES  = DATA_WIDTH / 8;
  localparam int CNT_W      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_A  = 2'd1,
    LOAD_B  = 2'd2,
    PRESENT = 2'd3
  } state_t;
endpackage

// File: rtl/and_operand_loader_if.sv
// Byte-stream input and operand-pair output of the loader, one bundle.
// Both sides use valid/ready: a beat moves on the rising edge where valid && ready.
interface and_operand_loader_if;
  import and_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [7:0]            in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, op_a, op_b
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, op_a, op_b
  );
endinterface

// File: rtl/and_operand_loader_byte_packer.sv
// Assembles one operand word a byte at a time; bytes overwrite in place.
module byte_packer #(
  parameter int NUM_BYTES = 4,
  parameter int CNT_W     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [CNT_W-1:0]       byte_idx,
  input  logic [7:0]             byte_in,
  output logic [8*NUM_BYTES-1:0] word_out
);
  logic [8*NUM_BYTES-1:0] r_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word <= '0;
    end else if (clear) begin
      r_word <= '0;
    end else if (wr_en) begin
      r_word[8*byte_idx +: 8] <= byte_in;
    end
  end

  assign word_out = r_word;
endmodule

// File: rtl/and_operand_loader.sv
// Byte-serial loader producing the A/B operand pair for the and_gate datapath.
// FSM and handshake live here; two byte_packers hold the operand words.
module and_operand_loader
  import and_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  and_operand_loader_if.slave  bus,
  output state_t               o_state,
  output logic [CNT_W-1:0]     o_byte_cnt
);
  state_t                r_state;
  logic [CNT_W-1:0]      r_byte_cnt;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic                  w_xfer;
  logic                  w_last;
  logic                  w_wr_a;
  logic                  w_wr_b;
  logic [DATA_WIDTH-1:0] w_op_a;
  logic [DATA_WIDTH-1:0] w_op_b;

  assign w_xfer = bus.in_valid && r_in_ready;
  assign w_last = (r_byte_cnt == CNT_W'(NUM_BYTES - 1));
  assign w_wr_a = w_xfer && !clear && (r_state == LOAD_A);
  assign w_wr_b = w_xfer && !clear && (r_state == LOAD_B);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_byte_cnt  <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (clear) begin
      r_state     <= IDLE;
      r_byte_cnt  <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state    <= LOAD_A;
          r_in_ready <= 1'b1;
        end
        LOAD_A: begin
          if (w_xfer) begin
            if (w_last) begin
              r_byte_cnt <= '0;
              r_state    <= LOAD_B;
            end else begin
              r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end
          end
        end
        LOAD_B: begin
          // in_ready drops on the edge that takes the last byte, so that byte is kept.
          if (w_xfer) begin
            if (w_last) begin
              r_byte_cnt  <= '0;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= PRESENT;
            end else begin
              r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end
          end
        end
        PRESENT: begin
          if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= LOAD_A;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  byte_packer #(.NUM_BYTES(NUM_BYTES), .CNT_W(CNT_W)) u_pack_a (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .wr_en    (w_wr_a),
    .byte_idx (r_byte_cnt),
    .byte_in  (bus.in_data),
    .word_out (w_op_a)
  );

  byte_packer #(.NUM_BYTES(NUM_BYTES), .CNT_W(CNT_W)) u_pack_b (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .wr_en    (w_wr_b),
    .byte_idx (r_byte_cnt),
    .byte_in  (bus.in_data),
    .word_out (w_op_b)
  );

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.op_a      = w_op_a;
  assign bus.op_b      = w_op_b;
  assign o_state       = r_state;
  assign o_byte_cnt    = r_byte_cnt;
endmodule

// File: tb/tb_and_operand_loader.sv
// Directed bench for and_operand_loader: driver tasks feed bytes, a monitor
// pops expected operand pairs from a queue on every output handshake.
module tb_and_operand_loader;
  import and_pkg::*;

  logic             clk;
  logic             reset;
  logic             clear;
  state_t           dbg_state;
  logic [CNT_W-1:0] dbg_cnt;
  int               n_tests;
  int               n_fail;
  logic [63:0]      exp_q[$];

  and_operand_loader_if bus();

  and_operand_loader dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .bus        (bus),
    .o_state    (dbg_state),
    .o_byte_cnt (dbg_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drivers: inputs change 1 time unit after the falling edge
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waits;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    waits = 0;
    while (!bus.in_ready && waits < 50) begin
      tick();
      waits++;
    end
    if (waits >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL in_ready_wait: got timeout expected in_ready=1");
    end
    tick();
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < NUM_BYTES; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
    exp_q.push_back({a, b});
    send_word(a);
    send_word(b);
    bus.in_valid = 1'b0;
  endtask

  // scoreboard monitor: samples between the driver update and the next rising edge
  always @(negedge clk) begin
    logic [63:0] e;
    #2;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pair: got %0h_%0h expected none", bus.op_a, bus.op_b);
      end else begin
        e = exp_q.pop_front();
        check("pair", {bus.op_a, bus.op_b}, e);
        check("and_c", {32'd0, bus.op_a & bus.op_b}, {32'd0, e[63:32] & e[31:0]});
      end
    end
  end

  initial begin
    logic [31:0] w;
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    clear = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    repeat (2) tick();

    check("rst_state", {62'd0, dbg_state}, 64'd0);
    check("rst_cnt", {{(64-CNT_W){1'b0}}, dbg_cnt}, 64'd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_ops", {bus.op_a, bus.op_b}, 64'd0);
    reset = 1'b0;

    // 1) basic stream D2 04 00 00 0F 27 00 00
    exp_q.push_back({32'd1234, 32'd9999});
    send_word(32'd1234);
    w = 32'd9999;
    for (int i = 0; i < NUM_BYTES - 1; i++) send_byte(w[8*i +: 8]);
    check("t1_ov_before_last", {63'd0, bus.out_valid}, 64'd0);
    send_byte(w[31:24]);
    bus.in_valid = 1'b0;
    check("t1_out_valid", {63'd0, bus.out_valid}, 64'd1);
    check("t1_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("t1_ops", {bus.op_a, bus.op_b}, {32'd1234, 32'd9999});
    check("t1_and_c", {32'd0, bus.op_a & bus.op_b}, 64'h0000_0402);

    // 2) hold in PRESENT while bytes are offered
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    repeat (5) begin
      tick();
      check("t2_ops_hold", {bus.op_a, bus.op_b}, {32'd1234, 32'd9999});
      check("t2_ov_hold", {63'd0, bus.out_valid}, 64'd1);
      check("t2_ir_low", {63'd0, bus.in_ready}, 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("t2_ov_drop", {63'd0, bus.out_valid}, 64'd0);
    check("t2_ir_rise", {63'd0, bus.in_ready}, 64'd1);
    check("t2_state", {62'd0, dbg_state}, {62'd0, LOAD_A});
    check("t2_cnt", {{(64-CNT_W){1'b0}}, dbg_cnt}, 64'd0);
    check("t2_op_a_persist", {32'd0, bus.op_a}, {32'd0, 32'd1234});

    // 3) stall after 2nd byte of A
    exp_q.push_back({32'd1234, 32'd9999});
    send_byte(8'hD2);
    send_byte(8'h04);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'hFF;
    repeat (3) begin
      tick();
      check("t3_cnt_hold", {{(64-CNT_W){1'b0}}, dbg_cnt}, 64'd2);
    end
    send_byte(8'h00);
    send_byte(8'h00);
    send_word(32'd9999);
    bus.in_valid = 1'b0;
    check("t3_ops", {bus.op_a, bus.op_b}, {32'd1234, 32'd9999});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // 4) clear after 5 bytes; the byte offered alongside is dropped
    send_word(32'd1234);
    send_byte(8'h0F);
    bus.in_data = 8'h55;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    bus.in_valid = 1'b0;
    check("t4_state", {62'd0, dbg_state}, 64'd0);
    check("t4_ops", {bus.op_a, bus.op_b}, 64'd0);
    check("t4_flags", {62'd0, bus.in_ready, bus.out_valid}, 64'd0);
    check("t4_cnt", {{(64-CNT_W){1'b0}}, dbg_cnt}, 64'd0);
    send_pair(32'd99999, 32'd9999);
    check("t4_ops_new", {bus.op_a, bus.op_b}, {32'd99999, 32'd9999});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // 5) async reset mid-LOAD_B, between edges
    send_word(32'd1234);
    send_byte(8'h0F);
    send_byte(8'h27);
    bus.in_valid = 1'b0;
    check("t5_in_load_b", {62'd0, dbg_state}, {62'd0, LOAD_B});
    reset = 1'b1;
    #1;
    check("t5_rst_ops", {bus.op_a, bus.op_b}, 64'd0);
    check("t5_rst_flags", {62'd0, bus.in_ready, bus.out_valid}, 64'd0);
    check("t5_rst_state", {62'd0, dbg_state}, 64'd0);
    #1;
    reset = 1'b0;
    #3;
    check("t5_ir_after_rel", {63'd0, bus.in_ready}, 64'd1);
    tick();

    // 6) back-to-back pairs, consumer always ready
    bus.out_ready = 1'b1;
    send_pair(32'd1234, 32'd9999);
    send_pair(32'd0, 32'd9999);
    check("t6_ops", {bus.op_a, bus.op_b}, {32'd0, 32'd9999});
    repeat (3) tick();
    bus.out_ready = 1'b0;
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
